// File: rtl/depp_stream_fifo_if.sv
// depp_stream_fifo_if: DEPP register bus plus H2U/U2H byte streams.
// slave = bridge side, master = decoder/user side.
interface depp_stream_fifo_if;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_wr;
  logic       reg_rd;
  logic [7:0] reg_rdata;
  logic       reg_hit;
  logic [7:0] h2u_data;
  logic       h2u_valid;
  logic       h2u_ready;
  logic [7:0] u2h_data;
  logic       u2h_valid;
  logic       u2h_ready;

  modport slave (
    input  reg_addr, reg_wdata, reg_wr, reg_rd,
    output reg_rdata, reg_hit,
    output h2u_data, h2u_valid,
    input  h2u_ready,
    input  u2h_data, u2h_valid,
    output u2h_ready
  );

  modport master (
    output reg_addr, reg_wdata, reg_wr, reg_rd,
    input  reg_rdata, reg_hit,
    input  h2u_data, h2u_valid,
    output h2u_ready,
    output u2h_data, u2h_valid,
    input  u2h_ready
  );
endinterface

// File: rtl/depp_stream_fifo.sv
// depp_stream_fifo: DEPP register window bridging to two byte FIFOs.
// Ports: clk, rst (sync, active-high), bus (depp_stream_fifo_if.slave).
module depp_stream_fifo #(
  parameter logic [7:0] ADDR_BASE  = 8'h7C,
  parameter int         DEPTH_LOG2 = 4
) (
  input logic               clk,
  input logic               rst,
  depp_stream_fifo_if.slave bus
);
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef logic [DEPTH_LOG2-1:0] ptr_t;
  typedef logic [CW-1:0]         cnt_t;

  localparam cnt_t       FULL_CNT = cnt_t'(DEPTH);
  localparam logic [7:0] A_H2U    = ADDR_BASE;
  localparam logic [7:0] A_U2H    = ADDR_BASE + 8'd1;
  localparam logic [7:0] A_STS    = ADDR_BASE + 8'd2;

  logic [7:0] h_mem_q [DEPTH];
  logic [7:0] u_mem_q [DEPTH];

  ptr_t       h_wptr_q, h_wptr_d, h_rptr_q, h_rptr_d;
  ptr_t       u_wptr_q, u_wptr_d, u_rptr_q, u_rptr_d;
  cnt_t       h_cnt_q, h_cnt_d, u_cnt_q, u_cnt_d;
  logic       ovf_q, ovf_d, udf_q, udf_d;
  logic [7:0] rdata_q, rdata_d;

  logic h_full, h_empty, u_full, u_empty;
  logic wr_h2u, wr_sts, rd_h2u, rd_u2h, rd_sts;
  logic h_push, h_pop, u_push, u_pop;
  logic [31:0] h_cnt_w;
  logic [7:0]  h_cnt_sat;
  logic [7:0]  status;

  assign h_full  = (h_cnt_q == FULL_CNT);
  assign h_empty = (h_cnt_q == '0);
  assign u_full  = (u_cnt_q == FULL_CNT);
  assign u_empty = (u_cnt_q == '0);

  assign wr_h2u = bus.reg_wr && (bus.reg_addr == A_H2U);
  assign wr_sts = bus.reg_wr && (bus.reg_addr == A_STS);
  assign rd_h2u = bus.reg_rd && (bus.reg_addr == A_H2U);
  assign rd_u2h = bus.reg_rd && (bus.reg_addr == A_U2H);
  assign rd_sts = bus.reg_rd && (bus.reg_addr == A_STS);

  // Full/empty are the pre-edge values, so a pop never makes
  // room for a push landing on the same edge.
  assign h_push = wr_h2u && !h_full;
  assign h_pop  = !h_empty && bus.h2u_ready;
  assign u_push = bus.u2h_valid && !u_full;
  assign u_pop  = rd_u2h && !u_empty;

  assign h_cnt_w   = 32'(h_cnt_q);
  assign h_cnt_sat = (h_cnt_w > 32'd255) ? 8'hFF : h_cnt_w[7:0];
  assign status    = {2'b00, udf_q, ovf_q,
                      u_full, u_empty, h_full, h_empty};

  always_comb begin
    h_wptr_d = h_wptr_q + ptr_t'(h_push);
    h_rptr_d = h_rptr_q + ptr_t'(h_pop);
    h_cnt_d  = h_cnt_q + cnt_t'(h_push) - cnt_t'(h_pop);
    u_wptr_d = u_wptr_q + ptr_t'(u_push);
    u_rptr_d = u_rptr_q + ptr_t'(u_pop);
    u_cnt_d  = u_cnt_q + cnt_t'(u_push) - cnt_t'(u_pop);
    // Set events override a same-cycle W1C.
    ovf_d = (wr_h2u && h_full) ||
            (ovf_q && !(wr_sts && bus.reg_wdata[4]));
    udf_d = (rd_u2h && u_empty) ||
            (udf_q && !(wr_sts && bus.reg_wdata[5]));
    rdata_d = rdata_q;
    unique case (1'b1)
      rd_u2h:  rdata_d = u_empty ? 8'h00 : u_mem_q[u_rptr_q];
      rd_sts:  rdata_d = status;
      rd_h2u:  rdata_d = h_cnt_sat;
      default: rdata_d = rdata_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_wptr_q <= '0;
      h_rptr_q <= '0;
      h_cnt_q  <= '0;
      u_wptr_q <= '0;
      u_rptr_q <= '0;
      u_cnt_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      rdata_q  <= 8'h00;
    end else begin
      h_wptr_q <= h_wptr_d;
      h_rptr_q <= h_rptr_d;
      h_cnt_q  <= h_cnt_d;
      u_wptr_q <= u_wptr_d;
      u_rptr_q <= u_rptr_d;
      u_cnt_q  <= u_cnt_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      rdata_q  <= rdata_d;
    end
  end

  // Storage needs no reset: zeroed pointers hide stale bytes.
  always_ff @(posedge clk) begin
    if (h_push) h_mem_q[h_wptr_q] <= bus.reg_wdata;
    if (u_push) u_mem_q[u_wptr_q] <= bus.u2h_data;
  end

  assign bus.reg_rdata = rdata_q;
  assign bus.reg_hit   = (bus.reg_addr >= A_H2U) &&
                         (bus.reg_addr <= A_STS);
  assign bus.h2u_data  = h_mem_q[h_rptr_q];
  assign bus.h2u_valid = !h_empty;
  assign bus.u2h_ready = !u_full;
endmodule
